tia_divide_by_n: RTL

Programmable two-phase clock generator, successor to the fixed divide-by-three stage. It divides `clk` by a runtime-loadable divisor D and emits non-overlapping `phi1`/`phi2` phase pulses plus a one-cycle `clkp` strobe per period. It supports synchronous phase restart (`rsyn`) and glitch-free divisor changes at period boundaries. It sits between the master oscillator and the TIA horizontal/colour logic.

---
 rtl/tia_divide_by_n_pkg.sv | 17 +
 rtl/tia_divide_by_n_if.sv | 41 ++++
 rtl/tia_divide_by_n_decode.sv | 29 ++
 rtl/tia_divide_by_n.sv | 91 +++++++++
 4 files changed

// File: rtl/tia_divide_by_n_pkg.sv
// Shared types and constants for the programmable two-phase clock generator.
// Provides MIN_DIV, the phase_t output bundle and a divisor legality helper.
package tia_clk_pkg;

  localparam int unsigned MIN_DIV = 4;

  typedef struct packed {
    logic phi1;
    logic phi2;
    logic clkp;
  } phase_t;

  function automatic logic div_legal(int unsigned d);
    return d >= MIN_DIV;
  endfunction

endpackage

// File: rtl/tia_divide_by_n_if.sv
// Control/status bundle of tia_divide_by_n.
// slave: restart/load in, phases/strobe/status out; master: the mirror side.
interface tia_divide_by_n_if #(
  parameter int CW = 4
);

  logic          rsyn;
  logic          div_load;
  logic [CW-1:0] div;
  logic          phi1;
  logic          phi2;
  logic          clkp;
  logic          rsyn_gated;
  logic [CW-1:0] div_active;
  logic          div_err;

  modport master (
    output rsyn,
    output div_load,
    output div,
    input  phi1,
    input  phi2,
    input  clkp,
    input  rsyn_gated,
    input  div_active,
    input  div_err
  );

  modport slave (
    input  rsyn,
    input  div_load,
    input  div,
    output phi1,
    output phi2,
    output clkp,
    output rsyn_gated,
    output div_active,
    output div_err
  );

endinterface

// File: rtl/tia_divide_by_n_decode.sv
// Phase decode: maps (next count, divisor D) to {phi1, phi2, clkp}.
// Ports: i_cnt next count, i_div divisor, o_ph decoded phases.
module tia_phase_decode
  import tia_clk_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic [CW-1:0] i_cnt,
  input  logic [CW-1:0] i_div,
  output phase_t        o_ph
);

  logic [CW-1:0] w_dm1;
  logic [CW-1:0] w_dm2;
  logic [CW-1:0] w_p;

  assign w_dm1 = i_div - CW'(1);
  assign w_dm2 = i_div - CW'(2);
  // P marks the single-cycle gap between phi1 and phi2
  assign w_p   = w_dm2 >> 1;

  always_comb begin
    o_ph      = '0;
    o_ph.phi1 = (i_cnt < w_p);
    o_ph.phi2 = (i_cnt > w_p) && (i_cnt <= w_dm2);
    o_ph.clkp = (i_cnt == w_dm1);
  end

endmodule

// File: rtl/tia_divide_by_n.sv
// Programmable divide-by-D two-phase clock generator with restart and staging.
// Ports: clk, resphi0_n (async low reset), bus (tia_divide_by_n_if.slave).
module tia_divide_by_n
  import tia_clk_pkg::*;
#(
  parameter int CW          = 4,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             resphi0_n,
  tia_divide_by_n_if.slave bus
);

  localparam logic [CW-1:0] RST_DIV = CW'(DEFAULT_DIV);
  localparam logic [CW-1:0] RST_CNT = CW'(DEFAULT_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_div_act;
  logic [CW-1:0] r_div_pend;
  logic          r_pend_vld;
  logic          r_phi1;
  logic          r_phi2;
  logic          r_clkp;
  logic          r_rsyn_gated;
  logic          r_div_err;

  logic          w_last;
  logic          w_bnd;
  logic          w_swap;
  logic          w_ld_ok;
  logic          w_ld_bad;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_div_nxt;
  phase_t        w_ph;

  assign w_last    = (r_cnt == r_div_act - CW'(1));
  assign w_bnd     = w_last | bus.rsyn;
  assign w_cnt_nxt = w_bnd ? '0 : r_cnt + CW'(1);
  // staged divisor takes over on the boundary and decodes the new cnt 0
  assign w_swap    = w_bnd & r_pend_vld;
  assign w_div_nxt = w_swap ? r_div_pend : r_div_act;
  assign w_ld_ok   = bus.div_load & div_legal(32'(bus.div));
  assign w_ld_bad  = bus.div_load & ~w_ld_ok;

  tia_phase_decode #(
    .CW (CW)
  ) u_dec (
    .i_cnt (w_cnt_nxt),
    .i_div (w_div_nxt),
    .o_ph  (w_ph)
  );

  always_ff @(posedge clk or negedge resphi0_n) begin
    if (!resphi0_n) begin
      r_cnt        <= RST_CNT;
      r_div_act    <= RST_DIV;
      r_div_pend   <= RST_DIV;
      r_pend_vld   <= 1'b0;
      r_phi1       <= 1'b0;
      r_phi2       <= 1'b0;
      r_clkp       <= 1'b0;
      r_rsyn_gated <= 1'b0;
      r_div_err    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_div_act <= w_div_nxt;
      r_phi1    <= w_ph.phi1;
      r_phi2    <= w_ph.phi2;
      r_clkp    <= w_ph.clkp;
      r_div_err <= w_ld_bad;
      // a load in the boundary cycle is staged for the following period
      if (w_ld_ok) begin
        r_div_pend <= bus.div;
        r_pend_vld <= 1'b1;
      end else if (w_swap) begin
        r_pend_vld <= 1'b0;
      end
      if (bus.rsyn) begin
        r_rsyn_gated <= ~w_last;
      end
    end
  end

  assign bus.phi1       = r_phi1;
  assign bus.phi2       = r_phi2;
  assign bus.clkp       = r_clkp;
  assign bus.rsyn_gated = r_rsyn_gated;
  assign bus.div_active = r_div_act;
  assign bus.div_err    = r_div_err;

endmodule
